// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: shared types and defaults for the unified memory port arbiter.
// Holds the FSM state enum, the transaction owner enum and the default
// starvation limit used when the fetch starvation guard is built in.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DATA = 2'd2
  } owner_t;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, data and memory-side signals of the
// arbiter. Modport master is the arbiter's view (it masters the memory port
// and answers the two requesters); modport slave is the surrounding system.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // instruction fetch side
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_flush;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  // load/store side
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_W-1:0]     d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [DATA_W/8-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;
  // memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;
  // pipeline halt
  logic                  fetch_stall;
  logic                  data_stall;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output fetch_stall, data_stall
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  fetch_stall, data_stall
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, one
// transaction in flight; grant is combinational in IDLE, best-case rvalid two
// cycles after grant; memory backpressure holds REQ with stable fields.
// Ports: clk, rst (async, active-high), bus (mem_port_arbiter_if.master).
// Optional: define MEMARB_STARVE_GUARD_EN to force a fetch grant after
// STARVE_MAX consecutive data grants taken while fetch was waiting.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = mem_arb_pkg::STARVE_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);
  import mem_arb_pkg::*;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
  end

  state_t              state_q, state_d;
  owner_t              owner_q, owner_d;
  logic                drop_q, drop_d;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W/8-1:0] mem_be_q;
  logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;

  logic if_gnt_c, d_gnt_c, if_rvalid_c, d_rvalid_c, mem_req_c;
  logic if_ok, force_if;

  // A flush in the same cycle as a fetch request withholds the fetch grant.
  assign if_ok = bus.if_req && !bus.if_flush;

`ifdef MEMARB_STARVE_GUARD_EN
  logic [3:0] starve_q;

  // Compared with >= and saturated so a flush-blocked forced cycle cannot
  // let the count run past the limit and starve fetch indefinitely.
  assign force_if = if_ok && (starve_q >= 4'(STARVE_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else if (state_q == ST_IDLE) begin
      if (if_gnt_c || !bus.if_req)
        starve_q <= 4'd0;
      else if (d_gnt_c && starve_q != 4'hF)
        starve_q <= starve_q + 4'd1;
    end
  end
`else
  assign force_if = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    if_gnt_c    = 1'b0;
    d_gnt_c     = 1'b0;
    if_rvalid_c = 1'b0;
    d_rvalid_c  = 1'b0;
    mem_req_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.d_req && !force_if) begin
          d_gnt_c = 1'b1;
          owner_d = OWN_DATA;
          state_d = ST_REQ;
        end else if (if_ok) begin
          if_gnt_c = 1'b1;
          owner_d  = OWN_IF;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_c = 1'b1;
        if (bus.if_flush && owner_q == OWN_IF) drop_d = 1'b1;
        if (bus.mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.if_flush && owner_q == OWN_IF) drop_d = 1'b1;
        if (bus.mem_rvalid) begin
          // A flush arriving with the response still discards it.
          if (owner_q == OWN_IF)   if_rvalid_c = !drop_q && !bus.if_flush;
          if (owner_q == OWN_DATA) d_rvalid_c  = 1'b1;
          state_d = ST_IDLE;
          owner_d = OWN_NONE;
          drop_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      drop_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      if (d_gnt_c) begin
        mem_we_q    <= bus.d_we;
        mem_addr_q  <= bus.d_addr;
        mem_wdata_q <= bus.d_wdata;
        mem_be_q    <= bus.d_be;
      end else if (if_gnt_c) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= bus.if_addr;
        mem_wdata_q <= '0;
        mem_be_q    <= '1;
      end
      if (if_rvalid_c) if_rdata_q <= bus.mem_rdata;
      if (d_rvalid_c)  d_rdata_q  <= bus.mem_rdata;
    end
  end

  // mem_req comes straight from the state register so reset drops it at once.
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

  assign bus.if_gnt    = if_gnt_c;
  assign bus.d_gnt     = d_gnt_c;
  assign bus.if_rvalid = if_rvalid_c;
  assign bus.d_rvalid  = d_rvalid_c;
  assign bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : if_rdata_q;
  assign bus.d_rdata   = d_rvalid_c  ? bus.mem_rdata : d_rdata_q;

  assign bus.fetch_stall = (bus.if_req || owner_q == OWN_IF)   && !if_rvalid_c;
  assign bus.data_stall  = (bus.d_req  || owner_q == OWN_DATA) && !d_rvalid_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int SMAX  = 2;
  localparam bit GUARD = 1'b1;
`else
  localparam int SMAX  = 4;
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // stimulus for the current cycle
  logic        r_if_req, r_if_flush, r_d_req, r_d_we, r_mg, r_mrv;
  logic [31:0] r_if_addr, r_d_addr, r_d_wdata, r_mrd;
  logic [3:0]  r_d_be;

  // reference model: the one transaction in flight, seen from outside
  bit          m_busy, m_acc, m_drop;
  int          m_who;            // 0 none, 1 fetch, 2 data
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_ifd, m_dd;
  logic [3:0]  m_be;
  int          m_starve;

  bit    g_ig, g_dg;
  string glog;
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    r_if_req = 0; r_if_flush = 0; r_if_addr = 0;
    r_d_req = 0; r_d_we = 0; r_d_addr = 0; r_d_wdata = 0; r_d_be = 0;
    r_mg = 0; r_mrv = 0; r_mrd = 0;
  endtask

  task automatic drive();
    bus.if_req = r_if_req; bus.if_addr = r_if_addr; bus.if_flush = r_if_flush;
    bus.d_req = r_d_req; bus.d_we = r_d_we; bus.d_addr = r_d_addr;
    bus.d_wdata = r_d_wdata; bus.d_be = r_d_be;
    bus.mem_gnt = r_mg; bus.mem_rvalid = r_mrv; bus.mem_rdata = r_mrd;
  endtask

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_drop = 0; m_who = 0; m_we = 0;
    m_addr = 0; m_wdata = 0; m_be = 0; m_ifd = 0; m_dd = 0; m_starve = 0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic check_cycle();
    bit iok, fi, dw, iw, e_mreq, resp, e_ir, e_dr, e_fs, e_ds;
    iok    = r_if_req && !r_if_flush;
    fi     = GUARD && iok && (m_starve >= SMAX);
    dw     = !m_busy && r_d_req && !fi;
    iw     = !m_busy && iok && !dw;
    e_mreq = m_busy && !m_acc;
    resp   = m_busy && m_acc && r_mrv;
    e_ir   = resp && m_who == 1 && !m_drop && !r_if_flush;
    e_dr   = resp && m_who == 2;
    e_fs   = (r_if_req || (m_busy && m_who == 1)) && !e_ir;
    e_ds   = (r_d_req  || (m_busy && m_who == 2)) && !e_dr;

    chk("if_gnt", bus.if_gnt, iw);
    chk("d_gnt", bus.d_gnt, dw);
    chk("mem_req", bus.mem_req, e_mreq);
    chk("if_rvalid", bus.if_rvalid, e_ir);
    chk("d_rvalid", bus.d_rvalid, e_dr);
    chk("fetch_stall", bus.fetch_stall, e_fs);
    chk("data_stall", bus.data_stall, e_ds);
    chk("if_rdata", bus.if_rdata, e_ir ? r_mrd : m_ifd);
    chk("d_rdata", bus.d_rdata, e_dr ? r_mrd : m_dd);
    if (e_mreq) begin
      chk("mem_we", bus.mem_we, m_we);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_be", bus.mem_be, m_be);
      if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    if (bus.d_gnt)  glog = {glog, "D"};
    if (bus.if_gnt) glog = {glog, "I"};
    g_ig = iw; g_dg = dw;

    if (e_ir) m_ifd = r_mrd;
    if (e_dr) m_dd  = r_mrd;
    if (!m_busy) begin
      if (iw || !r_if_req) m_starve = 0;
      else if (dw && m_starve < 15) m_starve++;
      if (dw) begin
        m_busy = 1; m_acc = 0; m_drop = 0; m_who = 2;
        m_we = r_d_we; m_addr = r_d_addr; m_wdata = r_d_wdata; m_be = r_d_be;
      end else if (iw) begin
        m_busy = 1; m_acc = 0; m_drop = 0; m_who = 1;
        m_we = 0; m_addr = r_if_addr; m_wdata = 0; m_be = 4'hF;
      end
    end else begin
      if (r_if_flush && m_who == 1) m_drop = 1;
      if (!m_acc) begin
        if (r_mg) m_acc = 1;
      end else if (r_mrv) begin
        m_busy = 0; m_acc = 0; m_drop = 0; m_who = 0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    #1;
    check_cycle();
  endtask

  // Let the memory answer promptly until the port is free, bounded.
  task automatic drain();
    clear_inputs();
    for (int k = 0; k < 10 && m_busy; k++) begin
      r_mg = 1; r_mrv = m_acc; r_mrd = $urandom;
      step();
    end
    chk("drain_done", m_busy, 0);
    clear_inputs();
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    clear_inputs();
    drive();
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_if_rvalid", bus.if_rvalid, 0);
    chk("rst_d_rvalid", bus.d_rvalid, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  bit          p_if, p_d, pd_we;
  logic [31:0] pa_if, pd_addr, pd_wd;
  logic [3:0]  pd_be;

  initial begin
    clear_inputs();
    model_reset();
    glog = "";
    drive();
    #1;
    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    chk("reset_mem_be", bus.mem_be, 0);
    chk("reset_if_rdata", bus.if_rdata, 0);
    chk("reset_d_rdata", bus.d_rdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // lone fetch
    clear_inputs(); r_if_req = 1; r_if_addr = 32'h100; step();
    chk("lone_if_gnt", bus.if_gnt, 1);
    clear_inputs(); r_mg = 1; step();
    chk("lone_mem_addr", bus.mem_addr, 32'h100);
    chk("lone_mem_be", bus.mem_be, 4'hF);
    clear_inputs(); r_mrv = 1; r_mrd = 32'hDEADBEEF; step();
    chk("lone_if_rdata", bus.if_rdata, 32'hDEADBEEF);
    chk("lone_fetch_stall", bus.fetch_stall, 0);

    // contention: store wins, fetch granted in the IDLE cycle after d_rvalid
    clear_inputs();
    r_if_req = 1; r_if_addr = 32'h300;
    r_d_req = 1; r_d_we = 1; r_d_addr = 32'h200; r_d_wdata = 32'h55; r_d_be = 4'h1;
    step();
    chk("cont_d_first", bus.d_gnt, 1);
    r_d_req = 0; r_mg = 1; step();
    chk("cont_mem_we", bus.mem_we, 1);
    chk("cont_mem_addr", bus.mem_addr, 32'h200);
    r_mg = 0; r_mrv = 1; r_mrd = 32'h0; step();
    chk("cont_no_gnt_on_resp", bus.if_gnt, 0);
    r_mrv = 0; step();
    chk("cont_if_after", bus.if_gnt, 1);
    drain();

    // memory backpressure on a load
    clear_inputs(); r_d_req = 1; r_d_addr = 32'h400; r_d_be = 4'hC; step();
    r_d_req = 0;
    for (int k = 0; k < 4; k++) begin
      r_mg = (k == 3); step();
      chk("bp_data_stall", bus.data_stall, 1);
    end
    r_mg = 0; r_mrv = 1; r_mrd = 32'hA5A5_0001; step();
    chk("bp_d_rdata", bus.d_rdata, 32'hA5A5_0001);

    // flush while the fetch waits for its response
    clear_inputs(); r_if_req = 1; r_if_addr = 32'h500; step();
    clear_inputs(); r_mg = 1; step();
    clear_inputs(); r_if_flush = 1; step();
    clear_inputs(); r_mrv = 1; r_mrd = 32'h1234; step();
    chk("flush_dropped", bus.if_rvalid, 0);
    clear_inputs(); r_if_req = 1; r_if_addr = 32'h104; step();
    clear_inputs(); r_mg = 1; step();
    clear_inputs(); r_mrv = 1; r_mrd = 32'hCAFE; step();
    chk("flush_next_ok", bus.if_rvalid, 1);

    // flush in IDLE blocks the fetch grant for that cycle
    clear_inputs(); r_if_req = 1; r_if_addr = 32'h600; r_if_flush = 1; step();
    chk("idle_flush_block", bus.if_gnt, 0);
    r_if_flush = 0; step();
    drain();

`ifdef MEMARB_STARVE_GUARD_EN
    pulse_reset();
    clear_inputs();
    r_if_req = 1; r_if_addr = 32'h700;
    r_d_req = 1; r_d_addr = 32'h800; r_d_be = 4'hF;
    glog = "";
    for (int k = 0; k < 18; k++) begin
      r_mg = 1; r_mrv = m_acc; r_mrd = $urandom;
      step();
    end
    chk("guard_sequence", glog == "DDIDDI", 1);
    drain();
`endif

    // reset in the middle of a fetch response wait
    clear_inputs(); r_if_req = 1; r_if_addr = 32'h900; step();
    clear_inputs(); r_mg = 1; step();
    pulse_reset();
    clear_inputs(); r_mrv = 1; r_mrd = 32'hBAD; step();
    chk("stray_if_rvalid", bus.if_rvalid, 0);
    chk("stray_d_rvalid", bus.d_rvalid, 0);
    clear_inputs(); r_d_req = 1; r_d_addr = 32'hA00; r_d_be = 4'h3; step();
    chk("post_rst_gnt", bus.d_gnt, 1);
    drain();

    // randomized traffic
    p_if = 0; p_d = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!p_if && $urandom_range(0, 2) == 0) begin
        p_if = 1; pa_if = $urandom;
      end
      if (!p_d && $urandom_range(0, 2) == 0) begin
        p_d = 1; pd_we = 1'($urandom_range(0, 1)); pd_addr = $urandom;
        pd_wd = $urandom; pd_be = 4'($urandom_range(0, 15));
      end
      r_if_req = p_if; r_if_addr = pa_if; r_if_flush = ($urandom_range(0, 7) == 0);
      r_d_req = p_d; r_d_we = pd_we; r_d_addr = pd_addr; r_d_wdata = pd_wd; r_d_be = pd_be;
      r_mg = 1'($urandom_range(0, 1));
      r_mrv = m_acc ? ($urandom_range(0, 2) == 0) : (m_busy && $urandom_range(0, 9) == 0);
      r_mrd = $urandom;
      step();
      if (g_ig) p_if = 0;
      if (g_dg) p_d = 0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
